// File: rtl/echo_delay_ctrl.sv
// Feedback echo/delay engine using an external dual-port RAM as a circular sample buffer.
// Define ECHO_CLEAR_EN to zero the whole buffer through port A after every reset.
module echo_delay_ctrl #(
    parameter int DEPTH       = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 24,
    parameter int DECAY_SHIFT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic [ADDR_WIDTH-1:0] delay_len,
    input  logic                  effect_en,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_out_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  ram_en_a,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic                  ram_en_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
);

    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] NEG_MAX = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WT,
        WR
`ifdef ECHO_CLEAR_EN
        , CLEAR
`endif
    } state_t;

`ifdef ECHO_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   wr_ptr, wr_ptr_nxt;
    logic [DATA_WIDTH-1:0]   x_reg, x_nxt;
    logic                    eff_reg, eff_nxt;

    logic [DATA_WIDTH-1:0]   out_nxt, din_a_nxt;
    logic [ADDR_WIDTH-1:0]   addr_a_nxt, addr_b_nxt;
    logic                    out_valid_nxt, en_a_nxt, en_b_nxt, busy_nxt, overrun_nxt;

`ifdef ECHO_CLEAR_EN
    logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_nxt;
    logic                    clr_done, clr_done_nxt;
`endif

    logic signed [DATA_WIDTH-1:0] d_shift;
    logic signed [DATA_WIDTH:0]   sum_wide;
    logic [DATA_WIDTH-1:0]        sum_sat;
    logic [DATA_WIDTH-1:0]        wr_val;

    // Sum is widened by one bit so overflow shows as the top two bits disagreeing.
    always_comb begin
        d_shift  = $signed(ram_dout_b) >>> DECAY_SHIFT;
        sum_wide = $signed({x_reg[DATA_WIDTH-1], x_reg}) + $signed({d_shift[DATA_WIDTH-1], d_shift});
        if (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]) begin
            sum_sat = sum_wide[DATA_WIDTH] ? NEG_MAX : POS_MAX;
        end else begin
            sum_sat = sum_wide[DATA_WIDTH-1:0];
        end
        wr_val = eff_reg ? sum_sat : x_reg;
    end

    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        x_nxt         = x_reg;
        eff_nxt       = eff_reg;
        out_nxt       = sample_out;
        din_a_nxt     = ram_din_a;
        addr_a_nxt    = ram_addr_a;
        addr_b_nxt    = ram_addr_b;
        out_valid_nxt = 1'b0;
        en_a_nxt      = 1'b0;
        en_b_nxt      = 1'b0;
        overrun_nxt   = sample_valid && (state != IDLE);
`ifdef ECHO_CLEAR_EN
        clr_cnt_nxt   = clr_cnt;
        clr_done_nxt  = clr_done;
`endif
        case (state)
            IDLE: begin
                if (sample_valid) begin
                    x_nxt      = sample_in;
                    eff_nxt    = effect_en;
                    en_b_nxt   = 1'b1;
                    addr_b_nxt = wr_ptr - delay_len;
                    state_nxt  = RD;
                end
            end
            RD: state_nxt = WT;
            WT: begin
                en_a_nxt      = 1'b1;
                addr_a_nxt    = wr_ptr;
                din_a_nxt     = wr_val;
                out_nxt       = wr_val;
                out_valid_nxt = 1'b1;
                state_nxt     = WR;
            end
            WR: begin
                wr_ptr_nxt = (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
                state_nxt  = IDLE;
            end
`ifdef ECHO_CLEAR_EN
            CLEAR: begin
                if (clr_done) begin
                    state_nxt = IDLE;
                end else begin
                    en_a_nxt    = 1'b1;
                    addr_a_nxt  = clr_cnt;
                    din_a_nxt   = '0;
                    clr_cnt_nxt = clr_cnt + 1'b1;
                    if (clr_cnt == PTR_MAX) clr_done_nxt = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= RESET_STATE;
            wr_ptr           <= '0;
            x_reg            <= '0;
            eff_reg          <= 1'b0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
            ram_en_a         <= 1'b0;
            ram_we_a         <= 1'b0;
            ram_addr_a       <= '0;
            ram_din_a        <= '0;
            ram_en_b         <= 1'b0;
            ram_addr_b       <= '0;
`ifdef ECHO_CLEAR_EN
            clr_cnt          <= '0;
            clr_done         <= 1'b0;
`endif
        end else begin
            state            <= state_nxt;
            wr_ptr           <= wr_ptr_nxt;
            x_reg            <= x_nxt;
            eff_reg          <= eff_nxt;
            sample_out       <= out_nxt;
            sample_out_valid <= out_valid_nxt;
            busy             <= busy_nxt;
            overrun          <= overrun_nxt;
            ram_en_a         <= en_a_nxt;
            ram_we_a         <= en_a_nxt;
            ram_addr_a       <= addr_a_nxt;
            ram_din_a        <= din_a_nxt;
            ram_en_b         <= en_b_nxt;
            ram_addr_b       <= addr_b_nxt;
`ifdef ECHO_CLEAR_EN
            clr_cnt          <= clr_cnt_nxt;
            clr_done         <= clr_done_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Bench for echo_delay_ctrl: bench-side RAM, per-sample reference model, per-cycle compare.
// Honours ECHO_CLEAR_EN by checking the post-reset clear sweep before re-enabling the model.
module tb_echo_delay_ctrl;

    localparam int AW  = 4;
    localparam int DW  = 24;
    localparam int DEP = 16;
    localparam int SH  = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic [AW-1:0] delay_len;
    logic          effect_en;
    logic [DW-1:0] sample_out;
    logic          sample_out_valid, busy, overrun;
    logic          ram_en_a, ram_we_a, ram_en_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_din_a, ram_dout_b;

    echo_delay_ctrl #(
        .DEPTH(DEP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DECAY_SHIFT(SH)
    ) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .delay_len(delay_len), .effect_en(effect_en), .sample_out(sample_out),
        .sample_out_valid(sample_out_valid), .busy(busy), .overrun(overrun),
        .ram_en_a(ram_en_a), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a),
        .ram_din_a(ram_din_a), .ram_en_b(ram_en_b), .ram_addr_b(ram_addr_b),
        .ram_dout_b(ram_dout_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // External RAM stand-in, with a bulk preload hook
    logic [DW-1:0] mem [DEP];
    logic [DW-1:0] pre [DEP];
    logic          preload_req = 1'b0;

    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < DEP; i++) mem[i] <= pre[i];
        end else if (ram_en_a && ram_we_a) begin
            mem[ram_addr_a] <= ram_din_a;
        end
        if (ram_en_b) ram_dout_b <= mem[ram_addr_b];
    end

    // Reference model: one entry per accepted sample, scheduled by cycle number
    logic [DW-1:0] mbuf [DEP];
    int            cyc = 0;
    int            m_wr_ptr = 0;
    int            busy_lo = 1, busy_hi = 0;
    int            ovr_cycle = -1, rst_cycle = -1, rd_cycle = -1, rd_addr = 0;
    bit            pend_active = 0;
    int            pend_cycle = 0, pend_addr = 0;
    logic [DW-1:0] pend_val = '0, last_out = '0;

    function automatic int sat(longint v);
        if (v > 64'sd8388607) return 8388607;
        if (v < -64'sd8388608) return -8388608;
        return int'(v);
    endfunction

    always @(posedge clk) begin
        int xi, di, yi, ra;
        if (preload_req) for (int i = 0; i < DEP; i++) mbuf[i] = pre[i];
        if (pend_active && pend_cycle == cyc) begin
            mbuf[pend_addr] = pend_val;
            last_out        = pend_val;
            pend_active     = 0;
        end
        if (reset) begin
            pend_active = 0;
            m_wr_ptr    = 0;
            busy_lo     = 1;
            busy_hi     = 0;
            rd_cycle    = -1;
            last_out    = '0;
            rst_cycle   = cyc + 1;
        end else if (sample_valid) begin
            if (cyc >= busy_lo && cyc <= busy_hi) begin
                ovr_cycle = cyc + 1;
            end else begin
                ra = (m_wr_ptr - int'(delay_len) + DEP) % DEP;
                xi = int'($signed(sample_in));
                di = int'($signed(mbuf[ra]));
                yi = effect_en ? sat(longint'(xi) + longint'(di >>> SH)) : xi;
                pend_active = 1;
                pend_cycle  = cyc + 3;
                pend_val    = DW'(yi);
                pend_addr   = m_wr_ptr;
                rd_cycle    = cyc + 1;
                rd_addr     = ra;
                busy_lo     = cyc + 1;
                busy_hi     = cyc + 3;
                m_wr_ptr    = (m_wr_ptr + 1) % DEP;
            end
        end
        cyc = cyc + 1;
    end

    // Per-cycle compare, plus logs used by the literal checks
    bit            chk_on = 0;
    int            we_seen = 0, ovr_seen = 0, last_wr_addr = -1;
    logic [DW-1:0] obs [$];

    always @(negedge clk) begin
        bit exp_wr;
        if (chk_on) begin
            exp_wr = pend_active && (pend_cycle == cyc);
            chk("out_valid", 32'(sample_out_valid), 32'(exp_wr));
            chk("en_a",      32'(ram_en_a),         32'(exp_wr));
            chk("we_a",      32'(ram_we_a),         32'(exp_wr));
            chk("en_b",      32'(ram_en_b),         32'(rd_cycle == cyc));
            chk("busy",      32'(busy),             32'(cyc >= busy_lo && cyc <= busy_hi));
            chk("overrun",   32'(overrun),          32'(ovr_cycle == cyc));
            chk("sample_out", 32'(sample_out),      32'(exp_wr ? pend_val : last_out));
            if (exp_wr) begin
                chk("addr_a", 32'(ram_addr_a), 32'(pend_addr));
                chk("din_a",  32'(ram_din_a),  32'(pend_val));
            end
            if (rd_cycle == cyc) chk("addr_b", 32'(ram_addr_b), 32'(rd_addr));
            if (rst_cycle == cyc) begin
                chk("rst_addr_a", 32'(ram_addr_a), 32'd0);
                chk("rst_din_a",  32'(ram_din_a),  32'd0);
                chk("rst_addr_b", 32'(ram_addr_b), 32'd0);
            end
            if (ram_en_a && ram_we_a) begin
                we_seen++;
                last_wr_addr = int'(ram_addr_a);
            end
            if (overrun) ovr_seen++;
            if (sample_out_valid) obs.push_back(sample_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] x, input logic [AW-1:0] dl, input logic en);
        sample_in    = x;
        delay_len    = dl;
        effect_en    = en;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic preload_all(input logic [DW-1:0] v);
        for (int i = 0; i < DEP; i++) pre[i] = v;
        preload_req = 1'b1;
        step();
        preload_req = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
`ifdef ECHO_CLEAR_EN
        begin
            int nw = 0, nb = 0, errs = 0;
            chk_on = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (busy) nb++;
                if (ram_en_a && ram_we_a) begin
                    if (int'(ram_addr_a) != nw || ram_din_a != '0) errs++;
                    nw++;
                end
            end
            chk("clear_writes", 32'(nw), 32'd16);
            chk("clear_busy",   32'(nb), 32'd16);
            chk("clear_order",  32'(errs), 32'd0);
            preload_all('0);
            chk_on = 1;
        end
`endif
    endtask

    initial begin
        int b, w0, o0;
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        delay_len    = '0;
        effect_en    = 1'b0;
        step();
        chk_on = 1;
        do_reset(2);
        preload_all('0);

        // Reset held two cycles while a sample is in flight
        w0 = we_seen;
        send(24'h000123, 4'd3, 1'b1);
        reset = 1'b1;
        step();
        step();
        chk("abort_no_write", 32'(we_seen - w0), 32'd0);
        do_reset(1);
        send(24'h000456, 4'd3, 1'b1);
        repeat (4) step();
        chk("after_abort_addr", 32'(last_wr_addr), 32'd0);

        // Impulse response through delay 4
        do_reset(1);
        preload_all('0);
        b = obs.size();
        for (int i = 0; i < 13; i++) begin
            send((i == 0) ? 24'd1000 : 24'd0, 4'd4, 1'b1);
            repeat (3) step();
        end
        chk("impulse_0",  32'(obs[b]),      32'd1000);
        chk("impulse_1",  32'(obs[b + 1]),  32'd0);
        chk("impulse_4",  32'(obs[b + 4]),  32'd500);
        chk("impulse_8",  32'(obs[b + 8]),  32'd250);
        chk("impulse_12", 32'(obs[b + 12]), 32'd125);

        // Saturation at both rails
        preload_all(24'h7FFFFF);
        send(24'h7FFFFF, 4'd5, 1'b1);
        repeat (3) step();
        chk("sat_pos", 32'(obs[obs.size() - 1]), 32'h7FFFFF);
        preload_all(24'h800000);
        send(24'h800000, 4'd9, 1'b1);
        repeat (3) step();
        chk("sat_neg", 32'(obs[obs.size() - 1]), 32'h800000);

        // Strobe two cycles after an accepted one is dropped
        do_reset(1);
        preload_all('0);
        w0 = we_seen;
        o0 = ovr_seen;
        send(24'h000010, 4'd1, 1'b1);
        step();
        send(24'h000020, 4'd1, 1'b1);
        repeat (4) step();
        chk("drop_overruns", 32'(ovr_seen - o0), 32'd1);
        chk("drop_writes",   32'(we_seen - w0),  32'd1);
        send(24'h000030, 4'd1, 1'b1);
        repeat (4) step();
        chk("drop_next_addr", 32'(last_wr_addr), 32'd1);

        // delay_len 0 means a full-buffer delay; pointer wraps
        do_reset(1);
        preload_all('0);
        b = obs.size();
        for (int i = 0; i < 20; i++) begin
            send((i == 0) ? 24'd4000 : 24'd0, 4'd0, 1'b1);
            repeat (3) step();
        end
        chk("wrap_first",   32'(obs[b]),      32'd4000);
        chk("wrap_echo16",  32'(obs[b + 16]), 32'd2000);
        chk("wrap_last_addr", 32'(last_wr_addr), 32'd3);

        // Randomized traffic over random buffer contents
        for (int i = 0; i < DEP; i++) pre[i] = DW'($urandom);
        preload_req = 1'b1;
        step();
        preload_req = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic [DW-1:0] x;
            case ($urandom_range(0, 5))
                0:       x = 24'h7FFFFF - DW'($urandom_range(0, 3));
                1:       x = 24'h800000 + DW'($urandom_range(0, 3));
                default: x = DW'($urandom);
            endcase
            if ($urandom_range(0, 99) == 0) do_reset(int'($urandom_range(1, 2)));
            else send(x, AW'($urandom_range(0, DEP - 1)), $urandom_range(0, 9) != 0);
            repeat ($urandom_range(0, 5)) step();
        end
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
